// File: rtl/stv_sync_fifo_pkt.sv
// Packet store-and-forward FIFO: words are written speculatively and become readable only once their packet commits.
// Latency: a committed word is visible on dout the cycle after its packet's last word is accepted (no pass-through).
// Backpressure: din_ready=!full while accepting; an over-long packet is absorbed (din_ready=1) and dropped; dout waits on dout_ready.
//
// Ports:
//   clk, arst_n, clear                  clock, async active-low reset, synchronous clear (highest priority)
//   din_valid/din_ready/din/din_last/din_drop   write side; din_drop qualifies the accepted last word
//   dout_valid/dout_ready/dout/dout_last        read side; committed data only
//   used_cnt, cmt_cnt, pkt_cnt          held entries (incl. speculative), readable entries, complete packets
//   empty, full, almost_empty, almost_full, ovf_drop   status flags; ovf_drop pulses once per overflow-discarded packet
module stv_sync_fifo_pkt #(
   parameter type data_t   = logic [7:0],
   parameter int  DEPTH    = 8,
   parameter bit  PKT_MODE = 1'b1,
   parameter int  AFULL    = DEPTH - 2,
   parameter int  AEMPTY   = 1,
   localparam int CNTWIDTH = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                arst_n,
   input  logic                clear,
   input  logic                din_valid,
   output logic                din_ready,
   input  data_t               din,
   input  logic                din_last,
   input  logic                din_drop,
   output logic                dout_valid,
   input  logic                dout_ready,
   output data_t               dout,
   output logic                dout_last,
   output logic [CNTWIDTH-1:0] used_cnt,
   output logic [CNTWIDTH-1:0] cmt_cnt,
   output logic [CNTWIDTH-1:0] pkt_cnt,
   output logic                empty,
   output logic                full,
   output logic                almost_empty,
   output logic                almost_full,
   output logic                ovf_drop
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic  last;
      data_t data;
   } entry_t;

   typedef enum logic {
      ST_ACCEPT  = 1'b0,
      ST_DISCARD = 1'b1
   } state_t;

   state_t          state_q, state_d;
   entry_t          mem [DEPTH];
   entry_t          rd_entry;
   logic [PW-1:0]   wptr_spec, wptr_cmt, rptr;
   logic [PW-1:0]   wptr_spec_nxt;

   logic            wr_acc, store, commit, commit_pkt, spec_rewind;
   logic            pop, pop_last, ovf_evt, in_accept;

   // Non-power-of-two depths wrap explicitly from DEPTH-1 back to 0.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) return '0;
      return p + PW'(1);
   endfunction

   // Status flags are pure decodes of the registered counters.
   assign empty        = (cmt_cnt == '0);
   assign full         = (used_cnt == CNTWIDTH'(DEPTH));
   assign almost_empty = (cmt_cnt <= CNTWIDTH'(AEMPTY));
   assign almost_full  = (used_cnt >= CNTWIDTH'(AFULL));

   assign rd_entry   = mem[rptr];
   assign dout       = rd_entry.data;
   assign dout_last  = rd_entry.last;
   assign dout_valid = !empty;

   assign in_accept     = (state_q == ST_ACCEPT);
   assign wr_acc        = din_valid && din_ready;
   assign wptr_spec_nxt = ptr_inc(wptr_spec);

   // A dropped last word is never written; in DISCARD nothing is written at all.
   assign store       = wr_acc && in_accept && !(PKT_MODE && din_last && din_drop);
   assign commit      = store && (din_last || !PKT_MODE);
   assign commit_pkt  = store && din_last;
   // Rewind on a bad packet, or at the end of an overflow-discarded packet.
   assign spec_rewind = wr_acc && din_last && (in_accept ? (PKT_MODE && din_drop) : 1'b1);
   assign ovf_evt     = wr_acc && din_last && !in_accept;

   assign pop      = dout_valid && dout_ready;
   assign pop_last = pop && rd_entry.last;

   // Overflow FSM: a packet that fills an otherwise empty (uncommitted-only) FIFO can never
   // complete, so the rest of it is swallowed and the whole packet is discarded.
   always_comb begin
      state_d   = state_q;
      din_ready = 1'b1;
      case (state_q)
         ST_ACCEPT: begin
            din_ready = !full;
            if (PKT_MODE && full && (cmt_cnt == '0) && din_valid) state_d = ST_DISCARD;
         end
         ST_DISCARD: begin
            din_ready = 1'b1;
            if (din_valid && din_last) state_d = ST_ACCEPT;
         end
         default: state_d = ST_ACCEPT;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q   <= ST_ACCEPT;
         wptr_spec <= '0;
         wptr_cmt  <= '0;
         rptr      <= '0;
         used_cnt  <= '0;
         cmt_cnt   <= '0;
         pkt_cnt   <= '0;
         ovf_drop  <= 1'b0;
      end else if (clear) begin
         state_q   <= ST_ACCEPT;
         wptr_spec <= '0;
         wptr_cmt  <= '0;
         rptr      <= '0;
         used_cnt  <= '0;
         cmt_cnt   <= '0;
         pkt_cnt   <= '0;
         ovf_drop  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ovf_drop <= ovf_evt;

         if (spec_rewind)  wptr_spec <= wptr_cmt;
         else if (store)   wptr_spec <= wptr_spec_nxt;

         if (commit) wptr_cmt <= wptr_spec_nxt;
         if (pop)    rptr     <= ptr_inc(rptr);

         // Rewinding throws away everything speculative, leaving only committed words.
         if (spec_rewind) used_cnt <= cmt_cnt - CNTWIDTH'(pop);
         else             used_cnt <= used_cnt + CNTWIDTH'(store) - CNTWIDTH'(pop);

         // On commit every held word (including the one being written) becomes readable.
         if (commit) cmt_cnt <= used_cnt + CNTWIDTH'(1) - CNTWIDTH'(pop);
         else        cmt_cnt <= cmt_cnt - CNTWIDTH'(pop);

         pkt_cnt <= pkt_cnt + CNTWIDTH'(commit_pkt) - CNTWIDTH'(pop_last);
      end
   end

   // Storage is intentionally not reset; readability is governed by the pointers.
   always_ff @(posedge clk) begin
      if (store && !clear) mem[wptr_spec] <= '{last: din_last, data: din};
   end

`ifndef SYNTHESIS
   a_din_stable: assert property (@(posedge clk) disable iff (!arst_n)
      (din_valid && !din_ready) |=> (din_valid && $stable(din) && $stable(din_last) && $stable(din_drop)))
      else $error("din changed while stalled");
`endif

endmodule

// File: tb/tb_stv_sync_fifo_pkt.sv
module tb_stv_sync_fifo_pkt;

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   always #5 clk = ~clk;

   // DEPTH=8 instance (a_*)
   logic       a_clear = 0, a_din_valid = 0, a_din_ready, a_din_last = 0, a_din_drop = 0;
   logic [7:0] a_din = '0, a_dout;
   logic       a_dout_valid, a_dout_ready = 0, a_dout_last;
   logic [3:0] a_used, a_cmt, a_pkt;
   logic       a_empty, a_full, a_ae, a_af, a_ovf;

   // DEPTH=6 instance (b_*)
   logic       b_clear = 0, b_din_valid = 0, b_din_ready, b_din_last = 0, b_din_drop = 0;
   logic [7:0] b_din = '0, b_dout;
   logic       b_dout_valid, b_dout_ready = 0, b_dout_last;
   logic [2:0] b_used, b_cmt, b_pkt;
   logic       b_empty, b_full, b_ae, b_af, b_ovf;

   stv_sync_fifo_pkt #(.DEPTH(8)) u_a (
      .clk(clk), .arst_n(arst_n), .clear(a_clear),
      .din_valid(a_din_valid), .din_ready(a_din_ready), .din(a_din),
      .din_last(a_din_last), .din_drop(a_din_drop),
      .dout_valid(a_dout_valid), .dout_ready(a_dout_ready), .dout(a_dout), .dout_last(a_dout_last),
      .used_cnt(a_used), .cmt_cnt(a_cmt), .pkt_cnt(a_pkt),
      .empty(a_empty), .full(a_full), .almost_empty(a_ae), .almost_full(a_af), .ovf_drop(a_ovf));

   stv_sync_fifo_pkt #(.DEPTH(6)) u_b (
      .clk(clk), .arst_n(arst_n), .clear(b_clear),
      .din_valid(b_din_valid), .din_ready(b_din_ready), .din(b_din),
      .din_last(b_din_last), .din_drop(b_din_drop),
      .dout_valid(b_dout_valid), .dout_ready(b_dout_ready), .dout(b_dout), .dout_last(b_dout_last),
      .used_cnt(b_used), .cmt_cnt(b_cmt), .pkt_cnt(b_pkt),
      .empty(b_empty), .full(b_full), .almost_empty(b_ae), .almost_full(b_af), .ovf_drop(b_ovf));

   int n_chk = 0;
   int n_fail = 0;
   int ovf_a = 0;
   int ovf_b = 0;
   logic streaming = 0;
   logic [8:0] exp_a[$];
   logic [8:0] exp_b[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Scoreboard monitors: every DUT pop is matched against the head of the expected queue.
   always @(negedge clk) begin
      logic [8:0] e;
      if (arst_n) begin
         if (a_ovf) ovf_a++;
         if (a_dout_valid && a_dout_ready) begin
            n_chk++;
            if (exp_a.size() == 0) begin
               n_fail++;
               $display("FAIL a_unexpected_pop: got last=%0b data=%h expected none", a_dout_last, a_dout);
            end else begin
               e = exp_a.pop_front();
               if ({a_dout_last, a_dout} !== e) begin
                  n_fail++;
                  $display("FAIL a_pop_data: got last=%0b data=%h expected last=%0b data=%h",
                           a_dout_last, a_dout, e[8], e[7:0]);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [8:0] e;
      if (arst_n) begin
         if (b_ovf) ovf_b++;
         if (streaming) chk("b_cmt_le1", 32'(b_cmt <= 3'd1), 1);
         if (b_dout_valid && b_dout_ready) begin
            n_chk++;
            if (exp_b.size() == 0) begin
               n_fail++;
               $display("FAIL b_unexpected_pop: got last=%0b data=%h expected none", b_dout_last, b_dout);
            end else begin
               e = exp_b.pop_front();
               if ({b_dout_last, b_dout} !== e) begin
                  n_fail++;
                  $display("FAIL b_pop_data: got last=%0b data=%h expected last=%0b data=%h",
                           b_dout_last, b_dout, e[8], e[7:0]);
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Holds the word until accepted; returns 1 time unit after the accepting edge.
   task automatic push_a(input logic [7:0] d, input logic l, input logic dr);
      int n;
      n = 0;
      a_din_valid = 1'b1; a_din = d; a_din_last = l; a_din_drop = dr;
      @(negedge clk);
      while (!a_din_ready && n < 40) begin n++; @(negedge clk); end
      chk("a_push_ready", 32'(a_din_ready), 1);
      @(posedge clk); #1;
      a_din_valid = 1'b0; a_din_last = 1'b0; a_din_drop = 1'b0;
   endtask

   task automatic push_b(input logic [7:0] d, input logic l);
      int n;
      n = 0;
      b_din_valid = 1'b1; b_din = d; b_din_last = l; b_din_drop = 1'b0;
      @(negedge clk);
      while (!b_din_ready && n < 40) begin n++; @(negedge clk); end
      chk("b_push_ready", 32'(b_din_ready), 1);
      @(posedge clk); #1;
      b_din_valid = 1'b0; b_din_last = 1'b0;
   endtask

   task automatic drain_a();
      int n;
      n = 0;
      while (exp_a.size() != 0 && n < 100) begin @(posedge clk); n++; end
      tick(1);
      chk("a_drain_done", exp_a.size(), 0);
   endtask

   task automatic drain_b();
      int n;
      n = 0;
      while (exp_b.size() != 0 && n < 100) begin @(posedge clk); n++; end
      tick(1);
      chk("b_drain_done", exp_b.size(), 0);
   endtask

   // Three-word packet, visible only after its last word; then read back.
   task automatic three_word_pkt(input logic [7:0] base);
      a_dout_ready = 1'b0;
      push_a(base + 8'd0, 1'b0, 1'b0);
      chk("s1_used1", a_used, 1);
      chk("s1_dv_w0", a_dout_valid, 0);
      push_a(base + 8'd1, 1'b0, 1'b0);
      chk("s1_used2", a_used, 2);
      chk("s1_cmt_w1", a_cmt, 0);
      chk("s1_dv_w1", a_dout_valid, 0);
      exp_a.push_back({1'b0, base + 8'd0});
      exp_a.push_back({1'b0, base + 8'd1});
      exp_a.push_back({1'b1, base + 8'd2});
      push_a(base + 8'd2, 1'b1, 1'b0);
      chk("s1_dv_after_last", a_dout_valid, 1);
      chk("s1_cmt3", a_cmt, 3);
      chk("s1_pkt1", a_pkt, 1);
      a_dout_ready = 1'b1;
      drain_a();
      chk("s1_pkt0", a_pkt, 0);
      chk("s1_empty", a_empty, 1);
      chk("s1_used0", a_used, 0);
   endtask

   initial begin
      tick(3);
      arst_n = 1'b1;

      // Reset state
      chk("rst_used", a_used, 0);
      chk("rst_cmt", a_cmt, 0);
      chk("rst_pkt", a_pkt, 0);
      chk("rst_empty", a_empty, 1);
      chk("rst_full", a_full, 0);
      chk("rst_ae", a_ae, 1);
      chk("rst_af", a_af, 0);
      chk("rst_dv", a_dout_valid, 0);
      chk("rst_ovf", a_ovf, 0);
      chk("rst_rdy", a_din_ready, 1);
      chk("rst_b_empty", b_empty, 1);

      // 1: basic store-and-forward
      three_word_pkt(8'hA0);

      // 2: bad packet discarded, following packet reuses the locations
      a_dout_ready = 1'b1;
      push_a(8'hC0, 1'b0, 1'b0);
      push_a(8'hC1, 1'b0, 1'b0);
      push_a(8'hC2, 1'b0, 1'b0);
      chk("s2_used3", a_used, 3);
      chk("s2_dv0", a_dout_valid, 0);
      push_a(8'hC3, 1'b1, 1'b1);
      chk("s2_used_after_drop", a_used, 0);
      chk("s2_empty", a_empty, 1);
      exp_a.push_back({1'b0, 8'hB0});
      exp_a.push_back({1'b1, 8'hB1});
      push_a(8'hB0, 1'b0, 1'b0);
      push_a(8'hB1, 1'b1, 1'b0);
      drain_a();
      chk("s2_pkt0", a_pkt, 0);

      // 3: oversize packet into empty FIFO is absorbed and dropped
      a_dout_ready = 1'b0;
      for (int i = 0; i < 8; i++) push_a(8'hD0 + 8'(i), 1'b0, 1'b0);
      chk("s3_used8", a_used, 8);
      chk("s3_full", a_full, 1);
      chk("s3_af", a_af, 1);
      push_a(8'hD8, 1'b0, 1'b0);
      chk("s3_ovf_none_yet", ovf_a, 0);
      push_a(8'hD9, 1'b1, 1'b0);
      chk("s3_ovf_pulse", a_ovf, 1);
      chk("s3_used0", a_used, 0);
      chk("s3_empty", a_empty, 1);
      tick(1);
      chk("s3_ovf_once", a_ovf, 0);
      chk("s3_rdy_accept", a_din_ready, 1);
      chk("s3_full0", a_full, 0);

      // 5: commit in the same cycle as popping the previous packet's last word
      a_dout_ready = 1'b0;
      exp_a.push_back({1'b0, 8'hE0});
      exp_a.push_back({1'b1, 8'hE1});
      push_a(8'hE0, 1'b0, 1'b0);
      push_a(8'hE1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         exp_a.push_back({1'b0, 8'hF0 + 8'(i)});
         push_a(8'hF0 + 8'(i), 1'b0, 1'b0);
      end
      exp_a.push_back({1'b1, 8'hF4});
      chk("s5_used6", a_used, 6);
      chk("s5_af_at6", a_af, 1);
      chk("s5_pkt1", a_pkt, 1);
      a_dout_ready = 1'b1;
      tick(1);
      a_dout_ready = 1'b0;
      chk("s5_used5", a_used, 5);
      chk("s5_af_at5", a_af, 0);
      chk("s5_cmt1", a_cmt, 1);
      a_dout_ready = 1'b1;
      push_a(8'hF4, 1'b1, 1'b0);
      chk("s5_pkt_net", a_pkt, 1);
      chk("s5_cmt_net", a_cmt, 5);
      chk("s5_used_net", a_used, 5);
      drain_a();
      chk("s5_pkt0", a_pkt, 0);

      // 6: clear mid-packet with a committed packet held
      a_dout_ready = 1'b0;
      push_a(8'h60, 1'b0, 1'b0);
      push_a(8'h61, 1'b0, 1'b0);
      push_a(8'h62, 1'b1, 1'b0);
      push_a(8'h63, 1'b0, 1'b0);
      push_a(8'h64, 1'b0, 1'b0);
      chk("s6_cmt3", a_cmt, 3);
      chk("s6_used5", a_used, 5);
      a_clear = 1'b1;
      tick(1);
      a_clear = 1'b0;
      chk("s6_used0", a_used, 0);
      chk("s6_cmt0", a_cmt, 0);
      chk("s6_pkt0", a_pkt, 0);
      chk("s6_empty", a_empty, 1);
      chk("s6_dv0", a_dout_valid, 0);
      chk("s6_rdy", a_din_ready, 1);
      three_word_pkt(8'h70);

      // 4: DEPTH=6 single-word packet stream, pointers wrap
      b_dout_ready = 1'b1;
      streaming = 1'b1;
      for (int i = 0; i < 20; i++) begin
         exp_b.push_back({1'b1, 8'h40 + 8'(i)});
         push_b(8'h40 + 8'(i), 1'b1);
      end
      drain_b();
      streaming = 1'b0;
      chk("s4_empty", b_empty, 1);
      // fill the whole DEPTH=6 memory with one packet across the wrap
      b_dout_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         exp_b.push_back({(i == 5), 8'h90 + 8'(i)});
         push_b(8'h90 + 8'(i), (i == 5));
      end
      chk("s4_full", b_full, 1);
      chk("s4_cmt6", b_cmt, 6);
      chk("s4_pkt1", b_pkt, 1);
      chk("s4_rdy0", b_din_ready, 0);
      b_dout_ready = 1'b1;
      drain_b();
      chk("s4_ovf_none", ovf_b, 0);

      chk("a_ovf_total", ovf_a, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
